// File: rtl/delay_sample_var_if.sv
// ---------------------------------------------------------------------------
// delay_sample_var_if
//   Sample-stream bundle for delay_sample_var.
//   master : producer/consumer side (drives data_in/input_strobe,
//            observes data_out/output_strobe/filled)
//   slave  : the delay line itself
// Signals:
//   data_in       - packed channel samples, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   input_strobe  - data_in valid
//   data_out      - delayed samples, registered
//   output_strobe - data_out valid, single cycle
//   filled        - line has refilled since the last restart
// ---------------------------------------------------------------------------
interface delay_sample_var_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_CH     = 2
) ();
    logic [DATA_WIDTH*NUM_CH-1:0] data_in;
    logic                         input_strobe;
    logic [DATA_WIDTH*NUM_CH-1:0] data_out;
    logic                         output_strobe;
    logic                         filled;

    modport master (
        output data_in,
        output input_strobe,
        input  data_out,
        input  output_strobe,
        input  filled
    );

    modport slave (
        input  data_in,
        input  input_strobe,
        output data_out,
        output output_strobe,
        output filled
    );
endinterface

// File: rtl/delay_sample_var.sv
// ---------------------------------------------------------------------------
// delay_sample_var
//   Runtime-programmable multi-channel sample delay line. Delays a strobed
//   stream by D accepted strobes (0..2^ADDR_WIDTH) using a circular buffer in
//   inferred dual-port RAM (read-before-write). Output strobes are suppressed
//   until the line has refilled after reset or a delay change.
//
// Optional feature macro: DELAY_SAMPLE_VAR_ZERO_FILL_EN
//   When defined, strobes accepted during fill still produce output_strobe
//   with all-zero data, keeping the downstream rate constant.
//
// Ports:
//   clock      - rising-edge clock
//   reset      - synchronous, active-high
//   enable     - low freezes all state and forces output_strobe low
//   delay      - requested delay, latched (clamped to DEPTH) on delay_load
//   delay_load - single-cycle pulse: latch delay, restart fill
//   bus        - stream bundle (slave modport): data_in, input_strobe,
//                data_out, output_strobe, filled
// ---------------------------------------------------------------------------
module delay_sample_var #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned ADDR_WIDTH    = 6,
    parameter int unsigned DEFAULT_DELAY = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [ADDR_WIDTH:0]   delay,
    input  logic                  delay_load,
    delay_sample_var_if.slave     bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned WIDTH = DATA_WIDTH * NUM_CH;
    localparam logic [ADDR_WIDTH:0] DEPTH_D = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] RESET_DELAY =
        (ADDR_WIDTH + 1)'((DEFAULT_DELAY > DEPTH) ? DEPTH : DEFAULT_DELAY);

    typedef enum logic [1:0] {
        SEL_HOLD,
        SEL_BYPASS,
        SEL_RAM,
        SEL_ZERO
    } out_sel_e;

    logic [WIDTH-1:0]      mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_addr_q,   wr_addr_d;
    logic [ADDR_WIDTH:0]   fill_cnt_q,  fill_cnt_d;
    logic [ADDR_WIDTH:0]   cur_delay_q, cur_delay_d;
    logic                  filled_q,    filled_d;
    logic                  ostb_q,      ostb_d;
    logic [WIDTH-1:0]      data_out_q;

    logic                  accept;
    logic                  load;
    logic [ADDR_WIDTH:0]   new_delay;
    logic [ADDR_WIDTH-1:0] rd_addr;
    out_sel_e              out_sel;

    function automatic logic [ADDR_WIDTH:0] clamp_delay(input logic [ADDR_WIDTH:0] d);
        return (d > DEPTH_D) ? DEPTH_D : d;
    endfunction

    assign accept    = enable && bus.input_strobe;
    assign load      = enable && delay_load;
    assign new_delay = clamp_delay(delay);
    // D = DEPTH has zero low bits, so read and write addresses coincide and
    // the read-before-write RAM returns the word written DEPTH strobes ago.
    assign rd_addr   = wr_addr_q - cur_delay_q[ADDR_WIDTH-1:0];

    always_comb begin
        wr_addr_d   = wr_addr_q;
        fill_cnt_d  = fill_cnt_q;
        cur_delay_d = cur_delay_q;
        filled_d    = filled_q;
        ostb_d      = 1'b0;
        out_sel     = SEL_HOLD;

        if (accept) begin
            wr_addr_d = wr_addr_q + 1'b1;
        end

        if (load) begin
            // A strobe coincident with the load is the first sample of the new
            // fill; it only produces output when the new delay is bypass.
            cur_delay_d = new_delay;
            filled_d    = (new_delay == '0);
            fill_cnt_d  = (accept && (new_delay != '0)) ? (ADDR_WIDTH + 1)'(1) : '0;
            if (accept && (new_delay == '0)) begin
                ostb_d  = 1'b1;
                out_sel = SEL_BYPASS;
            end
        end else if (accept) begin
            if (cur_delay_q == '0) begin
                ostb_d  = 1'b1;
                out_sel = SEL_BYPASS;
            end else if (fill_cnt_q == cur_delay_q) begin
                ostb_d   = 1'b1;
                out_sel  = SEL_RAM;
                filled_d = 1'b1;
            end else begin
                fill_cnt_d = fill_cnt_q + 1'b1;
`ifdef DELAY_SAMPLE_VAR_ZERO_FILL_EN
                ostb_d  = 1'b1;
                out_sel = SEL_ZERO;
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_addr_q   <= '0;
            fill_cnt_q  <= '0;
            cur_delay_q <= RESET_DELAY;
            filled_q    <= (RESET_DELAY == '0);
            ostb_q      <= 1'b0;
        end else begin
            wr_addr_q   <= wr_addr_d;
            fill_cnt_q  <= fill_cnt_d;
            cur_delay_q <= cur_delay_d;
            filled_q    <= filled_d;
            ostb_q      <= ostb_d;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            mem[wr_addr_q] <= bus.data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_out_q <= '0;
        end else begin
            case (out_sel)
                SEL_BYPASS: data_out_q <= bus.data_in;
                SEL_RAM:    data_out_q <= mem[rd_addr];
                SEL_ZERO:   data_out_q <= '0;
                default:    data_out_q <= data_out_q;
            endcase
        end
    end

    assign bus.data_out      = data_out_q;
    assign bus.output_strobe = ostb_q;
    assign bus.filled        = filled_q;

endmodule

// File: tb/tb_delay_sample_var.sv
module tb_delay_sample_var;

    localparam int unsigned DW = 16;
    localparam int unsigned NC = 2;
    localparam int unsigned AW = 6;
    localparam int unsigned DD = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic [AW:0]   delay;
    logic          delay_load;

    int vec_cnt = 0;
    int err_cnt = 0;

    delay_sample_var_if #(.DATA_WIDTH(DW), .NUM_CH(NC)) bus ();

    delay_sample_var #(
        .DATA_WIDTH(DW),
        .NUM_CH(NC),
        .ADDR_WIDTH(AW),
        .DEFAULT_DELAY(DD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .delay(delay),
        .delay_load(delay_load),
        .bus(bus)
    );

    always #5 clock = ~clock;

`ifdef DELAY_SAMPLE_VAR_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    typedef struct {
        logic        stb;
        int          din;
        logic        exp_ostb;
        logic [31:0] exp_dout;
        logic        exp_filled;
    } vec_t;

    vec_t tv [40];

    // Channel 1 carries a scrambled copy so channel swaps are visible.
    function automatic logic [31:0] mk(input int v);
        logic [15:0] l;
        l = v[15:0];
        return {l ^ 16'hA5A5, l};
    endfunction

    task automatic check(input string name, input logic exp_ostb, input logic chk_data,
                         input logic [31:0] exp_data, input logic exp_filled);
        bit bad;
        bad = 1'b0;
        vec_cnt++;
        if (bus.output_strobe !== exp_ostb) begin
            $display("FAIL %s: output_strobe=%0b expected %0b", name, bus.output_strobe, exp_ostb);
            bad = 1'b1;
        end
        if (chk_data && (bus.data_out !== exp_data)) begin
            $display("FAIL %s: data_out=%h expected %h", name, bus.data_out, exp_data);
            bad = 1'b1;
        end
        if (bus.filled !== exp_filled) begin
            $display("FAIL %s: filled=%0b expected %0b", name, bus.filled, exp_filled);
            bad = 1'b1;
        end
        if (bad) err_cnt++;
    endtask

    task automatic cycle(input logic en, input logic stb, input int din,
                         input logic ld, input int dly);
        enable           = en;
        bus.input_strobe = stb;
        bus.data_in      = mk(din);
        delay_load       = ld;
        delay            = dly[AW:0];
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input int d, input string name);
        cycle(1'b1, 1'b0, 0, 1'b1, d);
        check(name, 1'b0, 1'b0, '0, (d == 0));
    endtask

    // Stream n strobes starting right at a fill restart; data = base+i.
    // gap_mod > 0 inserts (i % gap_mod) idle cycles after strobe i.
    task automatic run_stream(input int n, input int base, input int d,
                              input int gap_mod, input string name, output int outs);
        logic ex_o, ex_f, ex_chk;
        logic [31:0] ex_d;
        int gap;
        outs = 0;
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b1, base + i, 1'b0, 0);
            if (d == 0) begin
                ex_o = 1'b1; ex_d = mk(base + i); ex_chk = 1'b1; ex_f = 1'b1;
            end else if (i >= d) begin
                ex_o = 1'b1; ex_d = mk(base + i - d); ex_chk = 1'b1; ex_f = 1'b1;
            end else begin
                ex_o = ZF; ex_d = '0; ex_chk = ZF; ex_f = 1'b0;
            end
            if (bus.output_strobe === 1'b1) outs++;
            check($sformatf("%s[%0d]", name, i), ex_o, ex_chk, ex_d, ex_f);
            gap = (gap_mod > 0) ? (i % gap_mod) : 0;
            for (int g = 0; g < gap; g++) begin
                cycle(1'b1, 1'b0, 16'hDEAD, 1'b0, 0);
                check($sformatf("%s_idle[%0d]", name, i), 1'b0, 1'b0, '0, ex_f);
            end
        end
    endtask

    initial begin
        int outs;

        reset            = 1'b1;
        enable           = 1'b1;
        delay            = '0;
        delay_load       = 1'b0;
        bus.input_strobe = 1'b0;
        bus.data_in      = '0;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("reset_state", 1'b0, 1'b1, '0, 1'b0);
        reset = 1'b0;

        // Default delay 16, 40 back-to-back strobes with data = index.
        for (int i = 0; i < 40; i++) begin
            tv[i].stb = 1'b1;
            tv[i].din = i;
            if (i >= 16) begin
                tv[i].exp_ostb   = 1'b1;
                tv[i].exp_dout   = mk(i - 16);
                tv[i].exp_filled = 1'b1;
            end else begin
                tv[i].exp_ostb   = ZF;
                tv[i].exp_dout   = '0;
                tv[i].exp_filled = 1'b0;
            end
        end
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, tv[i].stb, tv[i].din, 1'b0, 0);
            check($sformatf("default16[%0d]", i), tv[i].exp_ostb, 1'b1,
                  tv[i].exp_dout, tv[i].exp_filled);
        end

        // Delay 5 with 0..3 idle gaps.
        do_load(5, "load5");
        run_stream(30, 100, 5, 4, "d5", outs);
        vec_cnt++;
        if (outs != (ZF ? 30 : 25)) begin
            $display("FAIL d5_count: outputs=%0d expected %0d", outs, ZF ? 30 : 25);
            err_cnt++;
        end

        // Full depth: read/write address collision.
        do_load(64, "load64");
        run_stream(200, 1000, 64, 0, "d64", outs);

        // Above depth clamps to 64.
        do_load(100, "load100");
        run_stream(130, 3000, 64, 0, "d100", outs);

        // Bypass.
        do_load(0, "load0");
        run_stream(12, 4000, 0, 3, "d0", outs);

        // Coincident load mid-stream, 16 -> 3.
        do_load(16, "load16");
        run_stream(20, 5000, 16, 0, "d16", outs);
        cycle(1'b1, 1'b1, 6000, 1'b1, 3);
        check("coinc_load", 1'b0, 1'b1, mk(5003), 1'b0);
        cycle(1'b1, 1'b1, 6001, 1'b0, 0);
        check("coinc_fill2", ZF, 1'b1, ZF ? 32'h0 : mk(5003), 1'b0);
        cycle(1'b1, 1'b1, 6002, 1'b0, 0);
        check("coinc_fill3", ZF, 1'b1, ZF ? 32'h0 : mk(5003), 1'b0);
        cycle(1'b1, 1'b1, 6003, 1'b0, 0);
        check("coinc_first", 1'b1, 1'b1, mk(6000), 1'b1);
        cycle(1'b1, 1'b1, 6004, 1'b0, 0);
        check("coinc_second", 1'b1, 1'b1, mk(6001), 1'b1);

        // Enable low for 10 cycles: strobes and a load are ignored.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 9999, (i == 3), 0);
            check($sformatf("frozen[%0d]", i), 1'b0, 1'b1, mk(6001), 1'b1);
        end
        cycle(1'b1, 1'b1, 6005, 1'b0, 0);
        check("resume0", 1'b1, 1'b1, mk(6002), 1'b1);
        cycle(1'b1, 1'b1, 6006, 1'b0, 0);
        check("resume1", 1'b1, 1'b1, mk(6003), 1'b1);

        // Reset mid-stream restores default delay and restarts fill.
        reset = 1'b1;
        cycle(1'b1, 1'b1, 7777, 1'b0, 0);
        check("midreset", 1'b0, 1'b1, '0, 1'b0);
        reset = 1'b0;
        run_stream(20, 7000, 16, 0, "after_reset", outs);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
